// File: rtl/instruction_fetch_if.sv
// Instruction memory port: in-order word requests with valid/ready,
// responses with valid only (memory never backpressures a response).
interface instruction_fetch_if;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic        resp_valid;
    logic [31:0] resp_data;

    modport master (
        output req_valid, req_addr,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_addr,
        output req_ready, resp_valid, resp_data
    );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: PC owner, imem requester, 2-entry response queue, redirect squash.
// FETCH_PREFETCH_EN: two requests in flight; otherwise one at a time.
module instruction_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_stall_in,
    input  logic                       i_redirect_valid,
    input  logic [63:0]                i_redirect_pc,
    input  logic                       i_halt,
    instruction_fetch_if.master        imem,
    output logic                       o_pc_output_valid,
    output logic [31:0]                o_instruction,
    output logic [63:0]                o_instruction_pc
);

    logic [63:0] r_fetch_pc;
    logic [63:0] r_resp_pc;
    logic [31:0] r_q_instr [2];
    logic [63:0] r_q_pc    [2];
    logic        r_head;
    logic        r_tail;
    logic [1:0]  r_count;
    logic [1:0]  r_inflight;
    logic [1:0]  r_discard;
    logic        r_out_valid;
    logic [31:0] r_out_instr;
    logic [63:0] r_out_pc;

    logic        w_credit;
    logic        w_req_valid;
    logic        w_accept;
    logic        w_resp;
    logic        w_deliver;
    logic        w_pop;
    logic        w_bypass;
    logic        w_push;
    logic [63:0] w_target;

`ifdef FETCH_PREFETCH_EN
    assign w_credit = ({1'b0, r_count} + {1'b0, r_inflight}) < 3'd2;
`else
    assign w_credit = (r_inflight == 2'd0) && (r_count == 2'd0);
`endif

    assign w_req_valid = !rst && !i_halt && !i_redirect_valid && w_credit;
    assign w_accept    = w_req_valid && imem.req_ready;
    assign w_resp      = imem.resp_valid;
    assign w_deliver   = w_resp && (r_discard == 2'd0);
    assign w_pop       = !i_stall_in && (r_count != 2'd0);
    assign w_bypass    = !i_stall_in && (r_count == 2'd0) && w_deliver;
    assign w_push      = w_deliver && !w_bypass;
    assign w_target    = i_redirect_pc & ~64'h3;

    assign imem.req_valid = w_req_valid;
    assign imem.req_addr  = r_fetch_pc;

    assign o_pc_output_valid = r_out_valid;
    assign o_instruction     = r_out_instr;
    assign o_instruction_pc  = r_out_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc   <= RESET_PC;
            r_resp_pc    <= RESET_PC;
            r_q_instr[0] <= '0;
            r_q_instr[1] <= '0;
            r_q_pc[0]    <= '0;
            r_q_pc[1]    <= '0;
            r_head       <= 1'b0;
            r_tail       <= 1'b0;
            r_count      <= 2'd0;
            r_inflight   <= 2'd0;
            r_discard    <= 2'd0;
            r_out_valid  <= 1'b0;
            r_out_instr  <= '0;
            r_out_pc     <= '0;
        end else begin
            r_inflight <= r_inflight + {1'b0, w_accept} - {1'b0, w_resp};
            if (i_redirect_valid) begin
                // Everything still in flight belongs to the old path
                r_fetch_pc  <= w_target;
                r_resp_pc   <= w_target;
                r_head      <= 1'b0;
                r_tail      <= 1'b0;
                r_count     <= 2'd0;
                r_out_valid <= 1'b0;
                r_discard   <= r_inflight - {1'b0, w_resp};
            end else begin
                if (w_accept)
                    r_fetch_pc <= r_fetch_pc + 64'd4;
                if (w_resp && (r_discard != 2'd0))
                    r_discard <= r_discard - 2'd1;
                if (w_deliver)
                    r_resp_pc <= r_resp_pc + 64'd4;
                if (w_push) begin
                    r_q_instr[r_tail] <= imem.resp_data;
                    r_q_pc[r_tail]    <= r_resp_pc;
                    r_tail            <= ~r_tail;
                end
                if (w_pop) begin
                    r_out_valid <= 1'b1;
                    r_out_instr <= r_q_instr[r_head];
                    r_out_pc    <= r_q_pc[r_head];
                    r_head      <= ~r_head;
                end else if (w_bypass) begin
                    r_out_valid <= 1'b1;
                    r_out_instr <= imem.resp_data;
                    r_out_pc    <= r_resp_pc;
                end else if (!i_stall_in) begin
                    r_out_valid <= 1'b0;
                end
                r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized scoreboard bench for instruction_fetch with an in-order,
// variable-latency memory model and a PC-stream reference model.
module tb_instruction_fetch;

    localparam logic [63:0] RPC = 64'h1000;

    typedef struct {
        logic [63:0] addr;
        int          epoch;
        int          due;
    } mreq_t;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] ins;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [63:0] rpc = '0;
    logic        halt = 1'b0;
    logic        ov;
    logic [31:0] oi;
    logic [63:0] opc;

    instruction_fetch_if imem ();

    instruction_fetch #(.RESET_PC(RPC)) dut (
        .clk               (clk),
        .rst               (rst),
        .i_stall_in        (stall),
        .i_redirect_valid  (redirect),
        .i_redirect_pc     (rpc),
        .i_halt            (halt),
        .imem              (imem),
        .o_pc_output_valid (ov),
        .o_instruction     (oi),
        .o_instruction_pc  (opc)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          epoch = 0;
    int          last_due = 0;
    int          avail = 0;
    int          n_out = 0;
    int          n_acc = 0;
    logic [63:0] mpc = RPC;
    mreq_t       mq[$];
    exp_t        sb[$];
    bit          c_rst = 1'b1;
    bit          c_stall = 1'b0;
    bit          c_redir = 1'b0;
    bit          c_new = 1'b0;
    logic        pv = 1'b0;
    logic [31:0] pi = '0;
    logic [63:0] ppc = '0;

    function automatic logic [31:0] memword(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // One clock of stimulus plus memory model plus reference bookkeeping
    task automatic do_cycle(input bit st, input bit rd, input logic [63:0] tgt,
                            input bit hl, input bit rdy, input int lat_max);
        mreq_t h;
        bit    go;
        bit    good;
        bit    acc;
        int    due;
        @(negedge clk);
        rst      = 1'b0;
        stall    = st;
        redirect = rd;
        rpc      = tgt;
        halt     = hl;
        imem.req_ready = rdy;
        go = 1'b0;
        h  = '{addr: '0, epoch: -1, due: 0};
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            h  = mq.pop_front();
            go = 1'b1;
        end
        imem.resp_valid = go;
        imem.resp_data  = go ? memword(h.addr) : $urandom;
        #1;
        if (hl || rd)
            chk("req_gate", {63'd0, imem.req_valid}, 64'd0);
        acc = imem.req_valid && rdy;
        if (acc) begin
            chk("req_addr", imem.req_addr, mpc);
            due = cyc + $urandom_range(lat_max, 1);
            if (due < last_due) due = last_due;
            last_due = due;
            mq.push_back('{addr: imem.req_addr, epoch: epoch, due: due});
            sb.push_back('{pc: mpc, ins: memword(mpc)});
            mpc += 64'd4;
            n_acc++;
        end
        good    = go && (h.epoch == epoch) && !rd;
        c_rst   = 1'b0;
        c_stall = st;
        c_redir = rd;
        c_new   = !st && !rd && ((avail + int'(good)) > 0);
        if (rd) begin
            avail = 0;
            sb.delete();
            epoch++;
            mpc = tgt & ~64'h3;
        end else begin
            avail += int'(good);
            if (c_new) avail--;
        end
        cyc++;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst = 1'b1;
        stall = 1'b0;
        redirect = 1'b0;
        halt = 1'b0;
        imem.resp_valid = 1'b0;
        #1;
        chk("rst_valid", {63'd0, ov}, 64'd0);
        chk("rst_instr", {32'd0, oi}, 64'd0);
        chk("rst_pc", opc, 64'd0);
        chk("rst_req", {63'd0, imem.req_valid}, 64'd0);
        mq.delete();
        sb.delete();
        avail = 0;
        epoch++;
        mpc = RPC;
        last_due = 0;
        c_rst = 1'b1;
        cyc++;
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (c_rst) begin
            chk("reset_out", {ov, oi, opc}, 97'd0);
        end else if (c_redir) begin
            chk("squash", {63'd0, ov}, 64'd0);
        end else if (c_stall) begin
            chk("hold", {ov, oi, opc}, {pv, pi, ppc});
        end else if (c_new) begin
            chk("out_valid", {63'd0, ov}, 64'd1);
            if (sb.size() == 0) begin
                chk("sb_empty", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("out_pc", opc, e.pc);
                chk("out_instr", {32'd0, oi}, {32'd0, e.ins});
            end
            n_out++;
        end else begin
            chk("idle", {63'd0, ov}, 64'd0);
        end
        pv  = ov;
        pi  = oi;
        ppc = opc;
    end

    initial begin
        imem.req_ready  = 1'b0;
        imem.resp_valid = 1'b0;
        imem.resp_data  = '0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_req_low", {63'd0, imem.req_valid}, 64'd0);
        end

        // Streaming at 1-cycle latency
        n_out = 0;
        n_acc = 0;
        do_cycle(0, 0, '0, 0, 1, 1);
        chk("first_req", 64'(n_acc), 64'd1);
        repeat (19) do_cycle(0, 0, '0, 0, 1, 1);
        @(posedge clk);
        #2;
`ifdef FETCH_PREFETCH_EN
        chk("throughput", 64'(n_out), 64'd19);
`else
        chk("throughput", 64'(n_out), 64'd10);
`endif

        // Stall mid-stream, then release
        repeat (3) do_cycle(1, 0, '0, 0, 1, 1);
        repeat (4) do_cycle(0, 0, '0, 0, 1, 1);

        // Redirect with requests in flight, then while stalled
        repeat (2) do_cycle(0, 0, '0, 0, 1, 3);
        do_cycle(0, 1, 64'h2002, 0, 1, 3);
        repeat (6) do_cycle(0, 0, '0, 0, 1, 3);
        do_cycle(1, 0, '0, 0, 1, 1);
        do_cycle(1, 1, 64'h3000, 0, 1, 1);
        repeat (6) do_cycle(0, 0, '0, 0, 1, 1);

        // Wrap around the top of the address space
        do_cycle(0, 1, 64'hFFFF_FFFF_FFFF_FFF7, 0, 1, 2);
        repeat (8) do_cycle(0, 0, '0, 0, 1, 2);

        // Reset with the queue full
        repeat (4) do_cycle(1, 0, '0, 0, 1, 1);
        reset_pulse();
        repeat (6) do_cycle(0, 0, '0, 0, 1, 1);

        for (int i = 0; i < 3000; i++) begin
            logic [63:0] t;
            t = {$urandom, $urandom};
            if ($urandom_range(3, 0) == 0)
                t = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15, 0));
            if ($urandom_range(499, 0) == 0)
                reset_pulse();
            else
                do_cycle($urandom_range(3, 0) == 0,
                         $urandom_range(39, 0) == 0, t,
                         $urandom_range(29, 0) == 0,
                         $urandom_range(3, 0) != 0, 3);
        end

        // Halt: in-flight work drains, nothing new is requested
        for (int i = 0; i < 40; i++) begin
            if (mq.size() == 0 && sb.size() == 0 && avail == 0 && i > 4)
                break;
            do_cycle(0, 0, '0, 1, 1, 3);
        end
        repeat (3) do_cycle(0, 0, '0, 1, 1, 3);
        @(posedge clk);
        #2;
        chk("drain_sb", 64'(sb.size()), 64'd0);
        chk("drain_mem", 64'(mq.size()), 64'd0);
        chk("halt_idle", {63'd0, ov}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage feeding `instruction_decode`: owns the PC, issues in-order word requests to instruction memory, and buffers responses in a 2-entry queue. It presents latched `pc_output_valid`/`instruction`/`instruction_pc` to decode and honours decode's `stall_out` as backpressure. It redirects on taken branches/jumps from EX and drops stale in-flight responses after a redirect.

## Interface
- `RESET_PC`, default 64'h0: first fetch address after reset.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `stall_in`  in  1  decode's `stall_out`; hold output registers.
- `redirect_valid`  in  1  taken branch/jump from EX.
- `redirect_pc`  in  64  redirect target (`double_word`); bits [1:0] ignored, treated as 0.
- `halt`  in  1  final instruction seen; issue no new requests while high.
- `imem_req_valid`  out  1  request valid.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_req_addr`  out  64  word address (= fetch PC).
- `imem_resp_valid`  in  1  response data valid; in order, ≥1 cycle after accept, no backpressure.
- `imem_resp_data`  in  32  instruction word.
- `pc_output_valid`  out  1  latched: instruction valid to decode.
- `instruction`  out  32  latched instruction.
- `instruction_pc`  out  64  latched PC of `instruction`.

## Operation
- State: `fetch_pc`, queue (2 entries of {instr, pc}, head/tail pointers, count 0..2), `inflight` (0..2), `discard` (0..2).
- Request issue: `imem_req_valid = !rst && !halt && !redirect_valid && (count + inflight) < 2`; `imem_req_addr = fetch_pc`. On accept: `fetch_pc += 4` (64-bit, wraps mod 2^64), `inflight++`.
- Response: `inflight--`. If `discard > 0`: drop, `discard--`. Else deliver.
- Delivery priority when `!stall_in`: queue head → output; else bypass the same-cycle response → output; else `pc_output_valid <= 0`. A non-bypassed response is pushed into the queue. Each response enters the output or queue exactly once; order is preserved.
- `stall_in` high: output registers hold all values, including `pc_output_valid`; responses go to the queue. Credit rule guarantees the queue never overflows.
- Redirect (highest priority, overrides `stall_in`): on that edge `fetch_pc <= {redirect_pc[63:2],2'b00}`, queue cleared, `pc_output_valid <= 0`, `discard <= inflight` minus any response consumed that same cycle, no request issued that cycle.
- `halt`: stops issuing; already-returned and in-flight responses are still delivered.
- Simultaneous accept and response in one cycle: `inflight` unchanged.

## Timing
- Reset values: `pc_output_valid=0`, `instruction=0`, `instruction_pc=0`, `fetch_pc=RESET_PC`, count/inflight/discard=0. `imem_req_valid` is 0 while `rst` is high.
- First request is issued in the first cycle after `rst` deasserts.
- Latency: response in cycle N with empty queue and `!stall_in` → valid on outputs after the edge ending cycle N.
- Throughput: 1 instruction/cycle when memory latency is 1 and `FETCH_PREFETCH_EN` is defined.
- Reset asserted mid-operation clears all state immediately. Memory must also drop in-flight responses.

## Configuration
- `FETCH_PREFETCH_EN` defined: credit limit (count+inflight) < 2, as above.
- Undefined: at most one request outstanding and the queue is 1 deep: issue only when `inflight==0 && count==0`. Peak throughput is 1 instruction per 2 cycles at 1-cycle latency. All other behaviour is identical.

## Test plan
- Reset release, `RESET_PC=0x1000`, 1-cycle memory, no stalls → requests to 0x1000, 0x1004, 0x1008 on consecutive cycles. Outputs show (0x1000, w0), (0x1004, w1)… back-to-back with `pc_output_valid=1`.
- `stall_in` held 3 cycles mid-stream → outputs frozen on the same pc/instruction. Queue fills to 2 with no further requests. After release, the next two PCs appear on consecutive cycles with none lost or duplicated.
- Redirect to 0x2002 with 2 requests in flight → `pc_output_valid=0` next edge. Both stale responses are dropped. Next request address is 0x2000 and its instruction is the next valid output.
- Redirect while `stall_in=1` → the held output is squashed (`pc_output_valid=0`) and fetch restarts at the target.
- `halt` asserted after the request to 0x100C → no further requests; the 0x100C instruction is still delivered; outputs then go invalid.
- `rst` pulsed while the queue is full → all outputs are 0 immediately and fetch resumes at `RESET_PC`.
